// File: rtl/id_ex_stage_reg_if.sv
// ID -> EX bundle for the ID/EX pipeline register.
// master: ID-stage side (drives decoded fields, sees Stall_o and EX copies).
// slave:  the pipeline register itself.
// stall_count_o exists only when HAZARD_STALL_CNT_EN is defined.
interface id_ex_stage_reg_if #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 2
);
    logic               flush_i;
    logic [REG_AW-1:0]  IF_ID_RsAddr_i;
    logic [REG_AW-1:0]  IF_ID_RtAddr_i;
    logic [REG_AW-1:0]  RdAddr_i;
    logic [DATA_W-1:0]  RsData_i;
    logic [DATA_W-1:0]  RtData_i;
    logic [DATA_W-1:0]  Imm_i;
    logic               RegWrite_i;
    logic               MemtoReg_i;
    logic               MemRead_i;
    logic               MemWrite_i;
    logic               ALUSrc_i;
    logic               RegDst_i;
    logic [ALUOP_W-1:0] ALUOp_i;

    logic [REG_AW-1:0]  ID_EX_RsAddr_o;
    logic [REG_AW-1:0]  ID_EX_RtAddr_o;
    logic [REG_AW-1:0]  ID_EX_WrAddr_o;
    logic [DATA_W-1:0]  ID_EX_RsData_o;
    logic [DATA_W-1:0]  ID_EX_RtData_o;
    logic [DATA_W-1:0]  ID_EX_Imm_o;
    logic               ID_EX_RegWrite_o;
    logic               ID_EX_MemtoReg_o;
    logic               ID_EX_MemRead_o;
    logic               ID_EX_MemWrite_o;
    logic               ID_EX_ALUSrc_o;
    logic               ID_EX_RegDst_o;
    logic [ALUOP_W-1:0] ID_EX_ALUOp_o;
    logic               ID_EX_Valid_o;
    logic               Stall_o;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0]        stall_count_o;
`endif

    modport master (
        output flush_i, IF_ID_RsAddr_i, IF_ID_RtAddr_i, RdAddr_i,
               RsData_i, RtData_i, Imm_i,
               RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i, ALUOp_i,
        input  ID_EX_RsAddr_o, ID_EX_RtAddr_o, ID_EX_WrAddr_o,
               ID_EX_RsData_o, ID_EX_RtData_o, ID_EX_Imm_o,
               ID_EX_RegWrite_o, ID_EX_MemtoReg_o, ID_EX_MemRead_o, ID_EX_MemWrite_o,
               ID_EX_ALUSrc_o, ID_EX_RegDst_o, ID_EX_ALUOp_o, ID_EX_Valid_o, Stall_o
`ifdef HAZARD_STALL_CNT_EN
             , stall_count_o
`endif
    );

    modport slave (
        input  flush_i, IF_ID_RsAddr_i, IF_ID_RtAddr_i, RdAddr_i,
               RsData_i, RtData_i, Imm_i,
               RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i, ALUOp_i,
        output ID_EX_RsAddr_o, ID_EX_RtAddr_o, ID_EX_WrAddr_o,
               ID_EX_RsData_o, ID_EX_RtData_o, ID_EX_Imm_o,
               ID_EX_RegWrite_o, ID_EX_MemtoReg_o, ID_EX_MemRead_o, ID_EX_MemWrite_o,
               ID_EX_ALUSrc_o, ID_EX_RegDst_o, ID_EX_ALUOp_o, ID_EX_Valid_o, Stall_o
`ifdef HAZARD_STALL_CNT_EN
             , stall_count_o
`endif
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// A load in EX whose rt matches rs/rt of the instruction in ID raises Stall_o
// (combinational) and the next edge inserts a bubble instead of capturing.
// Optional macro HAZARD_STALL_CNT_EN adds a saturating 32-bit stall counter.
module id_ex_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    id_ex_stage_reg_if.slave bus
);
    logic [REG_AW-1:0]  rs_addr_reg, rt_addr_reg, wr_addr_reg;
    logic [DATA_W-1:0]  rs_data_reg, rt_data_reg, imm_reg;
    logic               reg_write_reg, memto_reg_reg, mem_read_reg, mem_write_reg;
    logic               alu_src_reg, reg_dst_reg, valid_reg;
    logic [ALUOP_W-1:0] alu_op_reg;

    logic               stall;
    logic [REG_AW-1:0]  wr_addr_next;

    // Load-use hazard: only registered EX state and the ID addresses feed this,
    // so flush_i never reaches Stall_o. r0 is hard-wired zero, so rt==0 is exempt.
    assign stall = mem_read_reg && (rt_addr_reg != '0) &&
                   ((rt_addr_reg == bus.IF_ID_RsAddr_i) || (rt_addr_reg == bus.IF_ID_RtAddr_i));

    // Destination register is resolved at capture so EX/MEM/WB only see one address.
    assign wr_addr_next = bus.RegDst_i ? bus.RdAddr_i : bus.IF_ID_RtAddr_i;

    // Pipeline register: reset > bubble (flush or stall) > capture.
    // A bubble clears control, valid and addresses; operand data is left holding.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rs_addr_reg   <= '0;
            rt_addr_reg   <= '0;
            wr_addr_reg   <= '0;
            rs_data_reg   <= '0;
            rt_data_reg   <= '0;
            imm_reg       <= '0;
            reg_write_reg <= 1'b0;
            memto_reg_reg <= 1'b0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            alu_src_reg   <= 1'b0;
            reg_dst_reg   <= 1'b0;
            alu_op_reg    <= '0;
            valid_reg     <= 1'b0;
        end else if (bus.flush_i || stall) begin
            rs_addr_reg   <= '0;
            rt_addr_reg   <= '0;
            wr_addr_reg   <= '0;
            reg_write_reg <= 1'b0;
            memto_reg_reg <= 1'b0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            alu_src_reg   <= 1'b0;
            reg_dst_reg   <= 1'b0;
            alu_op_reg    <= '0;
            valid_reg     <= 1'b0;
        end else begin
            rs_addr_reg   <= bus.IF_ID_RsAddr_i;
            rt_addr_reg   <= bus.IF_ID_RtAddr_i;
            wr_addr_reg   <= wr_addr_next;
            rs_data_reg   <= bus.RsData_i;
            rt_data_reg   <= bus.RtData_i;
            imm_reg       <= bus.Imm_i;
            reg_write_reg <= bus.RegWrite_i;
            memto_reg_reg <= bus.MemtoReg_i;
            mem_read_reg  <= bus.MemRead_i;
            mem_write_reg <= bus.MemWrite_i;
            alu_src_reg   <= bus.ALUSrc_i;
            reg_dst_reg   <= bus.RegDst_i;
            alu_op_reg    <= bus.ALUOp_i;
            valid_reg     <= 1'b1;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_count_reg;

    // Counts edges at which a stall was in effect; sticks at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_count_reg <= '0;
        end else if (stall && (stall_count_reg != 32'hFFFF_FFFF)) begin
            stall_count_reg <= stall_count_reg + 32'd1;
        end
    end

    assign bus.stall_count_o = stall_count_reg;
`endif

    assign bus.Stall_o          = stall;
    assign bus.ID_EX_RsAddr_o   = rs_addr_reg;
    assign bus.ID_EX_RtAddr_o   = rt_addr_reg;
    assign bus.ID_EX_WrAddr_o   = wr_addr_reg;
    assign bus.ID_EX_RsData_o   = rs_data_reg;
    assign bus.ID_EX_RtData_o   = rt_data_reg;
    assign bus.ID_EX_Imm_o      = imm_reg;
    assign bus.ID_EX_RegWrite_o = reg_write_reg;
    assign bus.ID_EX_MemtoReg_o = memto_reg_reg;
    assign bus.ID_EX_MemRead_o  = mem_read_reg;
    assign bus.ID_EX_MemWrite_o = mem_write_reg;
    assign bus.ID_EX_ALUSrc_o   = alu_src_reg;
    assign bus.ID_EX_RegDst_o   = reg_dst_reg;
    assign bus.ID_EX_ALUOp_o    = alu_op_reg;
    assign bus.ID_EX_Valid_o    = valid_reg;
endmodule
